// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and helpers for the skid-buffered pipeline stage.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL2 = 2'd2
    } state_t;

    function automatic logic [63:0] sat_max(input int w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at its all-ones value.
module sat_counter
    import pipe_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = W'(sat_max(W));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (inc && count != MAX)
            count <= count + W'(1);
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with a 2-entry skid buffer,
// synchronous flush and saturating bubble/flush counters.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    state_t state, state_n;
    logic [CTRL_W-1:0] m_ctrl, s_ctrl;
    logic [DATA_W-1:0] m_data, s_data;
    logic in_fire, out_fire, m_from_in, m_from_s, s_from_in;

    // Both handshake outputs depend only on the state register.
    assign in_ready  = state != FULL2;
    assign out_valid = state != EMPTY;
    assign out_ctrl  = out_valid ? m_ctrl : '0;
    assign out_data  = m_data;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_n   = state;
        m_from_in = 1'b0;
        m_from_s  = 1'b0;
        s_from_in = 1'b0;
        if (flush) begin
            state_n = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    state_n   = in_fire ? ONE : EMPTY;
                    m_from_in = in_fire;
                end
                ONE: begin
                    m_from_in = in_fire & out_fire;
                    s_from_in = in_fire & ~out_fire;
                    state_n   = s_from_in ? FULL2 : (out_fire & ~in_fire) ? EMPTY : ONE;
                end
                FULL2: begin
                    m_from_s = out_fire;
                    state_n  = out_fire ? ONE : FULL2;
                end
                default: state_n = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            m_ctrl <= '0;
            m_data <= '0;
            s_ctrl <= '0;
            s_data <= '0;
        end else begin
            state <= state_n;
            if (flush) begin
                m_ctrl <= '0;
                s_ctrl <= '0;
            end else begin
                if (m_from_in) begin
                    m_ctrl <= in_ctrl;
                    m_data <= in_data;
                end else if (m_from_s) begin
                    m_ctrl <= s_ctrl;
                    m_data <= s_data;
                end
                if (s_from_in) begin
                    s_ctrl <= in_ctrl;
                    s_data <= in_data;
                end
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_bubble (
        .clk   (clk),
        .rst   (rst),
        .inc   (~out_valid),
        .count (bubble_cnt)
    );

    // Only flushes that actually kill something are counted.
    sat_counter #(.W(CNT_W)) u_flush (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush & out_valid),
        .count (flush_cnt)
    );

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Generic, parametrised pipeline-stage register; the successor to the fixed-field ID/EX-style stage registers.
- Carries a control bundle and a data bundle between two pipeline stages with valid/ready handshaking, a 2-entry skid buffer, synchronous flush and saturating performance counters.
- Intended between any two stages (IF/ID, ID/EX, EX/MEM) so that stalls back-propagate without combinational paths from out_ready to in_ready.

Parameters:
CTRL_W, 8, width of control bundle (enable bits such as WB/MEM_R/MEM_W); forced to zero whenever out_valid=0
DATA_W, 64, width of data bundle (PC, operands, immediates, register tags); not cleared on flush
CNT_W, 16, width of each saturating performance counter

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous kill of all held entries and of the incoming beat this cycle
in_valid  in  1  upstream beat present
in_ready  out  1  stage can accept a beat; driven purely from state flops
in_ctrl  in  CTRL_W  upstream control bundle
in_data  in  DATA_W  upstream data bundle
out_valid  out  1  beat present at output
out_ready  in  1  downstream accepts beat
out_ctrl  out  CTRL_W  registered control; all zeros when out_valid=0
out_data  out  DATA_W  registered data; stable while out_valid=1 and out_ready=0
bubble_cnt  out  CNT_W  cycles with out_valid=0, saturating
flush_cnt  out  CNT_W  flushes that discarded at least one valid entry, saturating

Behaviour:
- Reset (async, rst=1): state=EMPTY; out_valid=0, out_ctrl=0, out_data=0, skid regs=0, in_ready=1, both counters=0.
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. Latency input to output: 1 cycle.
- in_ready = (state != FULL2). out_valid = (state != EMPTY).
- No combinational path from out_ready to in_ready, or from in_* to out_*.
- State is held in the main register M (the output) and the skid register S.
- Transitions when flush=0:
  - EMPTY: in_fire -> ONE, M<=in.
  - ONE, in_fire & out_fire: stay ONE, M<=in.
  - ONE, in_fire & !out_fire: -> FULL2, S<=in.
  - ONE, !in_fire & out_fire: -> EMPTY.
  - ONE, otherwise: hold.
  - FULL2 (in_ready=0), out_fire: -> ONE, M<=S.
  - FULL2, otherwise: hold.
- Ordering is strict FIFO: M is always older than S.
- Flush (highest priority below rst): next state EMPTY; M.ctrl and S.ctrl cleared; data registers may hold stale values.
  - An in_fire in the same cycle is discarded.
  - An out_fire in the same cycle still completes; downstream sees that beat.
  - in_ready=1 the following cycle.
- out_ctrl is gated: when out_valid=0, out_ctrl=0 regardless of M.ctrl.
- bubble_cnt: +1 on each clock edge where out_valid=0 and rst=0; holds at 2^CNT_W-1.
- flush_cnt: +1 on a flush edge where state!=EMPTY; holds at 2^CNT_W-1. Flush while EMPTY does not count.
- Reset mid-operation: all entries dropped immediately, outputs at reset values asynchronously, counters cleared.
- Throughput: 1 beat/cycle sustained when out_ready=1. A single out_ready=0 cycle is absorbed by S with no upstream stall on that cycle; in_ready falls only when S is occupied.

Decomposition:
- Shared package pipe_pkg:
  - typedef state_t {EMPTY, ONE, FULL2}, 2-bit encoding.
  - Localparam helper for counter saturation value.
- One sub-module, sat_counter (parameter W; ports clk, rst, inc, count), instantiated twice.
- Skid logic stays in the top module.

Test Plan:
- Reset: rst=1 mid-run with FULL2 -> same cycle out_valid=0, out_ctrl=0, in_ready=1, counters=0; after release, first beat ctrl=8'hA5 appears 1 cycle after in_fire.
- Streaming: 10 beats data=0..9 with out_ready=1 -> out_data 0..9 in order on consecutive cycles; bubble_cnt only counts the leading empty cycle(s).
- Backpressure: out_ready=0 for 3 cycles while feeding beats 1,2,3 -> in_ready drops after beat 2 is accepted; beat 3 is held upstream; releasing yields 1,2,3 in order with no loss or duplication.
- Flush in FULL2 with simultaneous in_valid=1 (data=7) and out_ready=1 -> M beat delivered; S and beat 7 discarded; next cycle out_valid=0, out_ctrl=0, in_ready=1; flush_cnt=1.
- Flush when EMPTY -> flush_cnt unchanged; bubble_cnt keeps incrementing.
- Saturation with CNT_W=4: hold out_valid=0 for 20 cycles -> bubble_cnt stops at 15; issue 17 flushes with ONE state -> flush_cnt=15.
